pmp_entry_match: RTL and testbench
==================================

Name: pmp_entry_match

Overview:
- Single Physical Memory Protection (PMP) address-matching entry for the RISC-V core's PMP unit.
- Given a physical address and one entry's pmpaddr/mode configuration, plus the previous entry's pmpaddr for TOR, it decides whether the address falls inside the entry's region.
- The result is registered (one-cycle latency).
- Instantiated once per PMP entry; the parent PMP unit does priority selection and permission checks.

Parameters:
- PLEN, 34, physical address width in bits (rv64: 56).
- PMP_LEN, 32, pmpaddr register width in bits. PMP_LEN must equal PLEN-2; elaboration error otherwise (rv64: 54).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- addr_i  input  PLEN  physical byte address to check.
- conf_addr_i  input  PMP_LEN  this entry's pmpaddr (byte address >> 2).
- conf_addr_prev_i  input  PMP_LEN  previous entry's pmpaddr (TOR lower bound); parent ties to 0 for entry 0.
- conf_addr_mode_i  input  2  address-matching mode: OFF=0, TOR=1, NA4=2, NAPOT=3 (riscv::pmp_addr_mode_t encoding).
- match_o  output  1  registered match result.

Behaviour:
- Reset: while rst_i is high at a rising edge, match_o <= 0. Inputs are ignored during that cycle.
- Latency: match_o at cycle N+1 reflects addr_i, conf_addr_i, conf_addr_prev_i and conf_addr_mode_i sampled at the rising edge of cycle N. No handshake; a new evaluation every cycle.
- Combinational match function m:
  - OFF: m = 0.
  - TOR:
    - m = (addr_i >= {conf_addr_prev_i,2'b00}) AND (addr_i < {conf_addr_i,2'b00}).
    - Unsigned compares at PLEN width.
    - If conf_addr_prev_i >= conf_addr_i, the range is empty and m = 0.
    - Lower bound inclusive, upper bound exclusive.
  - NA4: m = (addr_i[PLEN-1:2] == conf_addr_i). Covers the 4-byte region {conf_addr_i,2'b00}..+3.
  - NAPOT:
    - Let t = number of consecutive 1s in conf_addr_i starting at bit 0 (0..PMP_LEN).
    - Region size = 2^(t+3) bytes.
    - Base = {conf_addr_i,2'b00} with bits [t+2:0] cleared.
    - m = (addr_i[PLEN-1:t+3] == base[PLEN-1:t+3]).
    - t=0: 8-byte region.
    - t >= PLEN-3, including all-ones conf_addr_i: compare width is zero, m = 1 for every address.
- Mask generation must be purely combinational within one cycle: thermometer mask from trailing-ones detection, not a loop with data-dependent termination.
- Changing conf or mode mid-stream takes effect on the next registered output only; no other state is kept.
- Reset asserted mid-operation clears match_o on the next edge. The first post-reset result appears one cycle after rst_i deasserts.
- No X-propagation: any 2-bit mode value is one of the four defined modes.

Test Plan (PLEN=34, PMP_LEN=32):
- Reset: drive a matching NA4 config, assert rst_i for 2 cycles -> match_o=0 throughout; deassert -> match_o=1 one cycle later.
- TOR with prev=0x100, conf=0x200 (bytes 0x400..0x7FF):
  - addr 0x400 -> 1; addr 0x7FF -> 1.
  - addr 0x800 -> 0; addr 0x3FF -> 0.
  - With prev=0x200, conf=0x200 -> 0 for addr 0x800.
- NA4 with conf=0x1000: addr 0x4000, 0x4003 -> 1; addr 0x4004 -> 0; addr 0x3FFF -> 0.
- NAPOT with conf=0x1003 (t=2, 32 bytes at 0x4000): addr 0x4000, 0x401F -> 1; addr 0x4020, 0x3FFF -> 0.
- NAPOT with conf=0x1000 (t=0, 8 bytes): addr 0x4007 -> 1; addr 0x4008 -> 0.
- NAPOT with conf=0xFFFFFFFF -> 1 for addr 0x0 and 0x3_FFFF_FFFF. OFF with any conf/addr -> 0.
- Back-to-back: alternate addr 0x4000/0x5000 each cycle under NA4 conf=0x1000 -> match_o toggles 1/0 with exactly one-cycle lag.

Source files
------------

// File: rtl/pmp_entry_match.sv
// Single PMP address-matching entry: decides whether addr_i lies in this entry's
// region (OFF/TOR/NA4/NAPOT) and registers the result with one cycle of latency.
module pmp_entry_match #(
  parameter int unsigned PLEN    = 34,
  parameter int unsigned PMP_LEN = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [PLEN-1:0]    addr_i,
  input  logic [PMP_LEN-1:0] conf_addr_i,
  input  logic [PMP_LEN-1:0] conf_addr_prev_i,
  input  logic [1:0]         conf_addr_mode_i,
  output logic               match_o
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_TOR   = 2'd1,
    MODE_NA4   = 2'd2,
    MODE_NAPOT = 2'd3
  } addr_mode_e;

  if (PMP_LEN != PLEN - 2) begin : g_len_check
    $error("pmp_entry_match: PMP_LEN must equal PLEN-2");
  end

  addr_mode_e         mode;
  logic [PLEN-1:0]    tor_lo;
  logic [PLEN-1:0]    tor_hi;
  logic [PMP_LEN-1:0] addr_word;
  logic [PMP_LEN-1:0] napot_mask;
  logic               match_d;
  logic               match_q;

  assign mode      = addr_mode_e'(conf_addr_mode_i);
  assign tor_lo    = {conf_addr_prev_i, 2'b00};
  assign tor_hi    = {conf_addr_i, 2'b00};
  assign addr_word = addr_i[PLEN-1:2];

  // x ^ (x+1) sets bits [t:0], t = trailing-ones count: the pmpaddr bits that
  // fall inside the NAPOT region. All-ones conf wraps to an all-ones mask.
  assign napot_mask = conf_addr_i ^ (conf_addr_i + {{(PMP_LEN-1){1'b0}}, 1'b1});

  always_comb begin
    match_d = 1'b0;
    case (mode)
      MODE_OFF:   match_d = 1'b0;
      MODE_TOR:   match_d = (addr_i >= tor_lo) && (addr_i < tor_hi);
      MODE_NA4:   match_d = (addr_word == conf_addr_i);
      MODE_NAPOT: match_d = (((addr_word ^ conf_addr_i) & ~napot_mask) == '0);
      default:    match_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match_d;
    end
  end

  assign match_o = match_q;

endmodule

// File: tb/tb_pmp_entry_match.sv
// Scoreboard bench for pmp_entry_match: stimulus pushes expected results from a
// region-arithmetic model; a monitor pops and compares one cycle later.
module tb_pmp_entry_match;
  localparam int unsigned PLEN    = 34;
  localparam int unsigned PMP_LEN = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic [PLEN-1:0]    addr;
  logic [PMP_LEN-1:0] conf;
  logic [PMP_LEN-1:0] prev;
  logic [1:0]         mode;
  logic               match;

  typedef struct {
    bit    exp;
    string name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pmp_entry_match #(.PLEN(PLEN), .PMP_LEN(PMP_LEN)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .addr_i           (addr),
    .conf_addr_i      (conf),
    .conf_addr_prev_i (prev),
    .conf_addr_mode_i (mode),
    .match_o          (match)
  );

  // Reference: regions computed as byte ranges [base, base+size).
  function automatic bit model(input longint unsigned a, input longint unsigned c,
                               input longint unsigned p, input int md);
    longint unsigned size, base;
    int t;
    case (md)
      0: return 1'b0;
      1: return (a >= p * 4) && (a < c * 4);
      2: return (a / 4) == c;
      default: begin
        t = 0;
        while (t < 32 && c[t]) t++;
        size = 64'd1 << (t + 3);
        base = ((c * 4) / size) * size;
        return (a >= base) && (a < base + size);
      end
    endcase
  endfunction

  task automatic apply(input logic r, input logic [PLEN-1:0] a, input logic [PMP_LEN-1:0] c,
                       input logic [PMP_LEN-1:0] p, input logic [1:0] md, input string nm);
    exp_t e;
    @(negedge clk);
    rst  = r;
    addr = a;
    conf = c;
    prev = p;
    mode = md;
    e.exp  = r ? 1'b0 : model(64'(a), 64'(c), 64'(p), int'(md));
    e.name = nm;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (match !== e.exp) begin
          n_bad++;
          $display("FAIL %s: match_o=%b expected %b", e.name, match, e.exp);
        end
      end
    end
  end

  initial begin : stimulus
    logic [PLEN-1:0]    ra;
    logic [PMP_LEN-1:0] rc, rp;
    logic [1:0]         rm;
    longint unsigned    ones;
    int                 t, waited;

    rst = 1'b1; addr = '0; conf = '0; prev = '0; mode = 2'd0;

    apply(1'b1, 34'h4000, 32'h1000, 32'h0, 2'd2, "reset_c1");
    apply(1'b1, 34'h4000, 32'h1000, 32'h0, 2'd2, "reset_c2");
    apply(1'b0, 34'h4000, 32'h1000, 32'h0, 2'd2, "post_reset");

    apply(1'b0, 34'h400, 32'h200, 32'h100, 2'd1, "tor_lo_incl");
    apply(1'b0, 34'h7FF, 32'h200, 32'h100, 2'd1, "tor_hi_minus1");
    apply(1'b0, 34'h800, 32'h200, 32'h100, 2'd1, "tor_hi_excl");
    apply(1'b0, 34'h3FF, 32'h200, 32'h100, 2'd1, "tor_below_lo");
    apply(1'b0, 34'h800, 32'h200, 32'h200, 2'd1, "tor_empty");

    apply(1'b0, 34'h4000, 32'h1000, 32'h0, 2'd2, "na4_base");
    apply(1'b0, 34'h4003, 32'h1000, 32'h0, 2'd2, "na4_last");
    apply(1'b0, 34'h4004, 32'h1000, 32'h0, 2'd2, "na4_above");
    apply(1'b0, 34'h3FFF, 32'h1000, 32'h0, 2'd2, "na4_below");

    apply(1'b0, 34'h4000, 32'h1003, 32'h0, 2'd3, "napot32_base");
    apply(1'b0, 34'h401F, 32'h1003, 32'h0, 2'd3, "napot32_last");
    apply(1'b0, 34'h4020, 32'h1003, 32'h0, 2'd3, "napot32_above");
    apply(1'b0, 34'h3FFF, 32'h1003, 32'h0, 2'd3, "napot32_below");
    apply(1'b0, 34'h4007, 32'h1000, 32'h0, 2'd3, "napot8_last");
    apply(1'b0, 34'h4008, 32'h1000, 32'h0, 2'd3, "napot8_above");
    apply(1'b0, 34'h0,         32'hFFFF_FFFF, 32'h0, 2'd3, "napot_all_lo");
    apply(1'b0, 34'h3_FFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 2'd3, "napot_all_hi");
    apply(1'b0, 34'h2_0000_0000, 32'h7FFF_FFFF, 32'h0, 2'd3, "napot_t31");
    apply(1'b0, 34'h4000, 32'h1000, 32'h0, 2'd0, "off_na4cfg");
    apply(1'b0, 34'h0,    32'hFFFF_FFFF, 32'h0, 2'd0, "off_allones");

    for (int i = 0; i < 8; i++)
      apply(1'b0, (i % 2 == 0) ? 34'h4000 : 34'h5000, 32'h1000, 32'h0, 2'd2, "b2b_toggle");

    apply(1'b0, 34'h4000, 32'h1000, 32'h0, 2'd2, "pre_midreset");
    apply(1'b1, 34'h4000, 32'h1000, 32'h0, 2'd2, "midreset");
    apply(1'b0, 34'h4000, 32'h1000, 32'h0, 2'd2, "after_midreset");

    for (int i = 0; i < 400; i++) begin
      rm = 2'($urandom_range(0, 3));
      rc = $urandom;
      rp = $urandom;
      if (rm == 2'd3) begin
        t = $urandom_range(0, 33);
        ones = (t >= 32) ? 64'hFFFF_FFFF : ((64'd1 << t) - 1);
        rc = 32'((64'(rc) & ~((64'd1 << (t + 1)) - 1)) | ones);
      end
      if (rm == 2'd1 && $urandom_range(0, 1) == 1)
        rp = rc - 32'($urandom_range(0, 64));
      if ($urandom_range(0, 1) == 1)
        ra = {rc, 2'b00} + 34'($signed(32'($urandom_range(0, 80)) - 32'sd40));
      else
        ra = {2'($urandom_range(0, 3)), 32'($urandom)};
      apply(1'b0, ra, rc, rp, rm, "random");
    end

    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
